// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: shared definitions for the run/step controller.
//   STATE_W : width of the controller state (debug LED field)
//   state_t : FSM state encoding (IDLE=00, RUN=01, STEP=10, HALTED=11)
package run_ctrl_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_STEP   = 2'b10,
        ST_HALTED = 2'b11
    } state_t;

endpackage

// File: rtl/run_controller_button_debouncer.sv
// button_debouncer: conditions a raw pushbutton into a one-cycle press request.
//   2-flop synchronizer -> optional debounce filter -> rising-edge detect.
//   Debounce filter is built only when RUN_CTRL_DEBOUNCE_EN is defined;
//   otherwise the edge detector works on the synchronized level directly.
// Parameters:
//   DEBOUNCE_CYCLES : consecutive stable cycles needed to accept a level change
//   DB_WIDTH        : debounce counter width, 2**DB_WIDTH > DEBOUNCE_CYCLES
// Ports:
//   clk      in  system clock
//   reset_n  in  asynchronous active-low reset
//   btn      in  raw asynchronous button level
//   step_req out one-cycle pulse per accepted press
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned DB_WIDTH        = 20
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn,
    output logic step_req
);

    // Reject a counter too narrow to ever reach the terminal count.
    if ((64'd1 << DB_WIDTH) <= 64'(DEBOUNCE_CYCLES)) begin : g_bad_db_width
        $error("button_debouncer: DB_WIDTH too small for DEBOUNCE_CYCLES");
    end

    logic sync1;
    logic sync2;
    logic level;
    logic level_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

`ifdef RUN_CTRL_DEBOUNCE_EN
    localparam logic [DB_WIDTH-1:0] DB_LAST = DB_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [DB_WIDTH-1:0] db_cnt;
    logic                stable;

    // Any cycle where sync2 agrees with the accepted level restarts the run,
    // so only an uninterrupted run of DEBOUNCE_CYCLES differing samples flips it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            db_cnt <= '0;
            stable <= 1'b0;
        end else if (sync2 == stable) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            db_cnt <= '0;
            stable <= sync2;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    assign level = stable;
`else
    assign level = sync2;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_d  <= 1'b0;
            step_req <= 1'b0;
        end else begin
            level_d  <= level;
            step_req <= level & ~level_d;
        end
    end

endmodule

// File: rtl/run_controller.sv
// run_controller: run/step controller for the 16-bit CPU.
//   Turns pulse-generator ticks (free-run) or debounced STEP presses into a
//   single-cycle CPU clock enable, and gates the pulse generator while not
//   free-running. Optional button debounce: define RUN_CTRL_DEBOUNCE_EN.
// Parameters:
//   DEBOUNCE_CYCLES, DB_WIDTH : debounce filter length / counter width
//   STEP_COUNT_WIDTH          : width of step_count
// Ports:
//   clk        in  system clock
//   reset_n    in  asynchronous active-low reset
//   run_sw     in  1 = free-run mode (synchronous level)
//   step_btn   in  raw bouncing STEP pushbutton
//   tick       in  one-cycle pulse from pulse generator
//   halt       in  1 = CPU executed HLT
//   tick_en    out pulse generator enable, 1 exactly while in RUN
//   cpu_ce     out one-cycle CPU clock enable
//   state      out FSM state for debug LEDs
//   step_count out number of cpu_ce pulses issued (wraps)
module run_controller
    import run_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES  = 1_000_000,
    parameter int unsigned DB_WIDTH         = 20,
    parameter int unsigned STEP_COUNT_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        run_sw,
    input  logic                        step_btn,
    input  logic                        tick,
    input  logic                        halt,
    output logic                        tick_en,
    output logic                        cpu_ce,
    output logic [STATE_W-1:0]          state,
    output logic [STEP_COUNT_WIDTH-1:0] step_count
);

    state_t state_q;
    state_t state_next;
    logic   cpu_ce_next;
    logic   tick_en_next;
    logic   step_req;

    button_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .DB_WIDTH        (DB_WIDTH)
    ) u_step_btn (
        .clk      (clk),
        .reset_n  (reset_n),
        .btn      (step_btn),
        .step_req (step_req)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cpu_ce     <= 1'b0;
            tick_en    <= 1'b0;
            step_count <= '0;
        end else begin
            state_q <= state_next;
            cpu_ce  <= cpu_ce_next;
            tick_en <= tick_en_next;
            if (cpu_ce) begin
                step_count <= step_count + 1'b1;
            end
        end
    end

    always_comb begin
        state_next  = state_q;
        cpu_ce_next = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (halt) begin
                    state_next = ST_HALTED;
                end else if (run_sw) begin
                    state_next = ST_RUN;
                end else if (step_req) begin
                    state_next  = ST_STEP;
                    cpu_ce_next = 1'b1;
                end
            end
            ST_RUN: begin
                if (halt) begin
                    state_next = ST_HALTED;
                end else if (!run_sw) begin
                    state_next = ST_IDLE;
                end else begin
                    // A tick only advances the CPU when the FSM stays in RUN.
                    cpu_ce_next = tick;
                end
            end
            ST_STEP: begin
                state_next = halt ? ST_HALTED : ST_IDLE;
            end
            ST_HALTED: begin
                if (!halt) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        // Registered from next state so tick_en tracks state == RUN exactly.
        tick_en_next = (state_next == ST_RUN);
    end

    assign state = state_q;

endmodule

// File: tb/tb_run_controller.sv
// Self-checking bench for run_controller (STEP_COUNT_WIDTH=4, DEBOUNCE_CYCLES=8).
module tb_run_controller;

    localparam int unsigned SCW = 4;
`ifdef RUN_CTRL_DEBOUNCE_EN
    localparam int STEP_LAT   = 4 + 8;
    localparam int WRAP_TICKS = 4;
`else
    localparam int STEP_LAT   = 4;
    localparam int WRAP_TICKS = 5;
`endif

    logic           clk = 1'b0;
    logic           reset_n;
    logic           run_sw;
    logic           step_btn;
    logic           tick;
    logic           halt;
    logic           tick_en;
    logic           cpu_ce;
    logic [1:0]     state;
    logic [SCW-1:0] step_count;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int exp_q[$];

    typedef struct {
        logic       run_sw;
        logic       tick;
        logic       halt;
        logic [1:0] exp_state;
        logic       exp_tick_en;
        logic       exp_ce;
    } vec_t;

    vec_t vecs[15];

    run_controller #(
        .DEBOUNCE_CYCLES  (8),
        .DB_WIDTH         (4),
        .STEP_COUNT_WIDTH (SCW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .run_sw     (run_sw),
        .step_btn   (step_btn),
        .tick       (tick),
        .halt       (halt),
        .tick_en    (tick_en),
        .cpu_ce     (cpu_ce),
        .state      (state),
        .step_count (step_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Scoreboard: each expected cpu_ce carries the cycle it must appear in.
    always @(negedge clk) begin
        if (exp_q.size() != 0 && exp_q[0] < cyc) begin
            checks++;
            failures++;
            $display("FAIL ce_missing: got none expected pulse at cycle %0d", exp_q[0]);
            void'(exp_q.pop_front());
        end
        if (reset_n && cpu_ce) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL ce_unexpected: got pulse at cycle %0d expected none", cyc);
            end else if (exp_q[0] != cyc) begin
                failures++;
                $display("FAIL ce_timing: got cycle %0d expected cycle %0d", cyc, exp_q[0]);
                void'(exp_q.pop_front());
            end else begin
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        //          run tick halt state  te ce
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};

        reset_n  = 1'b0;
        run_sw   = 1'b0;
        step_btn = 1'b0;
        tick     = 1'b0;
        halt     = 1'b0;
        #1;
        check("reset_state",   32'(state),      32'd0);
        check("reset_tick_en", 32'(tick_en),    32'd0);
        check("reset_cpu_ce",  32'(cpu_ce),     32'd0);
        check("reset_count",   32'(step_count), 32'd0);
        wait_cycles(2);
        reset_n = 1'b1;
        wait_cycles(1);
        check("idle_after_reset", 32'(state), 32'd0);

        // Single-cycle FSM transitions and cpu_ce gating.
        for (int i = 0; i < 15; i++) begin
            run_sw = vecs[i].run_sw;
            tick   = vecs[i].tick;
            halt   = vecs[i].halt;
            if (vecs[i].exp_ce) exp_q.push_back(cyc + 1);
            @(negedge clk);
            check($sformatf("vec%0d_state", i),   32'(state),   32'(vecs[i].exp_state));
            check($sformatf("vec%0d_tick_en", i), 32'(tick_en), 32'(vecs[i].exp_tick_en));
        end
        tick = 1'b0;
        wait_cycles(1);
        check("table_count", 32'(step_count), 32'd2);

        // Asynchronous reset while a cpu_ce pulse is live in RUN.
        run_sw = 1'b1;
        wait_cycles(1);
        tick = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0;
        check("pre_reset_ce",      32'(cpu_ce),  32'd1);
        check("pre_reset_tick_en", 32'(tick_en), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check("async_rst_ce",      32'(cpu_ce),     32'd0);
        check("async_rst_tick_en", 32'(tick_en),    32'd0);
        check("async_rst_state",   32'(state),      32'd0);
        check("async_rst_count",   32'(step_count), 32'd0);
        run_sw = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        wait_cycles(1);
        check("rst_release_idle", 32'(state), 32'd0);

        // Free run: 10 ticks, one every 5 cycles.
        run_sw = 1'b1;
        wait_cycles(1);
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < 5; j++) begin
                tick = (j == 0);
                if (j == 0) exp_q.push_back(cyc + 1);
                @(negedge clk);
                if (j == 1) check("run_tick_en", 32'(tick_en), 32'd1);
            end
        end
        tick = 1'b0;
        wait_cycles(2);
        check("run_count", 32'(step_count), 32'd10);
        run_sw = 1'b0;
        wait_cycles(1);
        check("run_exit_state",   32'(state),   32'd0);
        check("run_exit_tick_en", 32'(tick_en), 32'd0);

        // Two held presses with a release in between: one step each.
        for (int p = 0; p < 2; p++) begin
            step_btn = 1'b1;
            exp_q.push_back(cyc + STEP_LAT);
            wait_cycles(STEP_LAT);
            check("step_state", 32'(state), 32'd2);
            wait_cycles(30 - STEP_LAT);
            step_btn = 1'b0;
            wait_cycles(30);
        end
        check("step_count", 32'(step_count), 32'd12);

`ifdef RUN_CTRL_DEBOUNCE_EN
        // Bounce every 3 cycles, then settle high: one step after the filter.
        for (int b = 0; b < 6; b++) begin
            step_btn = (b % 2 == 0);
            wait_cycles(3);
        end
        step_btn = 1'b1;
        exp_q.push_back(cyc + STEP_LAT);
        wait_cycles(20);
        step_btn = 1'b0;
        wait_cycles(20);
        check("bounce_count", 32'(step_count), 32'd13);
`endif

        // Tick and halt together in RUN; presses ignored while halted.
        run_sw = 1'b1;
        wait_cycles(1);
        tick = 1'b1;
        halt = 1'b1;
        wait_cycles(1);
        tick = 1'b0;
        check("halt_state",   32'(state),   32'd3);
        check("halt_tick_en", 32'(tick_en), 32'd0);
        check("halt_cpu_ce",  32'(cpu_ce),  32'd0);
        step_btn = 1'b1;
        wait_cycles(25);
        check("halt_hold_state", 32'(state), 32'd3);
        run_sw = 1'b0;
        halt   = 1'b0;
        wait_cycles(1);
        check("halt_release_state", 32'(state), 32'd0);
        wait_cycles(5);
        check("held_btn_no_step", 32'(state), 32'd0);
        step_btn = 1'b0;
        wait_cycles(25);

        // Counter wrap: total pulses since reset reach 17 on a 4-bit counter.
        run_sw = 1'b1;
        wait_cycles(1);
        for (int i = 0; i < WRAP_TICKS; i++) begin
            tick = 1'b1;
            exp_q.push_back(cyc + 1);
            wait_cycles(1);
            tick = 1'b0;
            wait_cycles(2);
        end
        wait_cycles(2);
        check("wrap_count", 32'(step_count), 32'd1);
        run_sw = 1'b0;
        wait_cycles(5);
        check("ce_pending", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/run_controller.md
# run_controller

Run/step controller for the 16-bit CPU: consumes the one-cycle `tick` from the pulse generator and a raw STEP pushbutton, and produces the single-cycle `cpu_ce` clock-enable that advances the CPU. It also drives the pulse generator's `enable`, so the generator only counts while the CPU is free-running. The block sits between the board I/O and pulse generator on one side and the CPU core on the other.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles needed to accept a button level change (10 ms at 100 MHz).
- `DB_WIDTH`, default 20: width of the debounce counter. Must satisfy 2^DB_WIDTH > DEBOUNCE_CYCLES.
- `STEP_COUNT_WIDTH`, default 16: width of `step_count`.

Ports:
- `clk`  in  1  system clock. One clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `run_sw`  in  1  level input; 1 = free-run mode. Already synchronous to `clk`.
- `step_btn`  in  1  raw, asynchronous, bouncing pushbutton.
- `tick`  in  1  one-cycle pulse from the pulse generator.
- `halt`  in  1  level input from the CPU; 1 = HLT has been executed.
- `tick_en`  out  1  enable for the pulse generator.
- `cpu_ce`  out  1  one-cycle CPU clock enable.
- `state`  out  2  FSM state, for debug LEDs.
- `step_count`  out  STEP_COUNT_WIDTH  number of `cpu_ce` pulses issued.

## Operation
- Reset values: all outputs 0, FSM in IDLE, synchronizer and debounce registers 0.
- Button path:
  - 2-flop synchronizer.
  - Debounce filter (see Configuration).
  - Rising-edge detect, producing a one-cycle `step_req`.
- FSM states and encodings: IDLE=00, RUN=01, STEP=10, HALTED=11.
  - IDLE: if `halt`, go to HALTED; else if `run_sw`, go to RUN; else if `step_req`, go to STEP.
  - RUN: if `halt`, go to HALTED; else if `!run_sw`, go to IDLE; else stay in RUN. `step_req` is ignored.
  - STEP: lasts exactly one cycle. Next state is HALTED if `halt`, else IDLE.
  - HALTED: if `!halt`, go to IDLE. `run_sw` and `step_req` are ignored.
- Priority: `halt` > `run_sw` > `step_req`.
- `tick_en` is a registered output, equal to 1 exactly while the state is RUN. Leaving RUN therefore clears the generator's count.
- `cpu_ce` is registered and is 1 when either:
  - the FSM enters STEP, or
  - the FSM is in RUN, samples `tick`=1 with `run_sw`=1 and `halt`=0, and stays in RUN.
- `step_count` increments on every cycle with `cpu_ce`=1. It wraps modulo 2^STEP_COUNT_WIDTH and has no saturation.

## Timing
- RUN: `tick` sampled high at edge k gives `cpu_ce`=1 for the cycle after edge k (1-cycle latency). `step_count` updates at edge k+1.
- STEP without the debouncer: `step_btn` first sampled high at edge k:
  - `sync2` is high after edge k+1.
  - `step_req` is high after edge k+2.
  - STEP and `cpu_ce`=1 after edge k+3.
- STEP with the debouncer: add DEBOUNCE_CYCLES cycles to the latency above.
- Boundary cases:
  - `tick` and `halt` in the same cycle: no `cpu_ce`; go to HALTED.
  - `tick` in the same cycle `run_sw` falls: no `cpu_ce`.
  - `step_req` while in STEP: ignored. Each STEP visit yields exactly one `cpu_ce`.
  - `reset_n` asserted mid-STEP or mid-RUN: outputs go to 0 immediately (asynchronous); no partial pulse is stretched.
  - Holding the button produces one step only. A new step needs a release followed by a press.

## Configuration
- `RUN_CTRL_DEBOUNCE_EN` defined:
  - The debounce counter restarts at 0 whenever `sync2` equals `stable`, and otherwise increments.
  - When the counter reaches DEBOUNCE_CYCLES-1, `stable` takes the value of `sync2` and the counter returns to 0.
  - Edge detection operates on `stable`.
- `RUN_CTRL_DEBOUNCE_EN` undefined: no counter is instantiated and edge detection operates on `sync2` directly. This is used for simulation and for externally debounced inputs.

## Structure
- Package `run_ctrl_pkg`: the state encoding constants (ST_IDLE, ST_RUN, ST_STEP, ST_HALTED) and the state width.
- Sub-module `button_debouncer`: synchronizer, optional debounce filter and edge detector, with output `step_req`. It is reusable for the other board buttons.
- The top level holds the FSM, the `cpu_ce`/`tick_en` registers and `step_count`.

## Test plan
- Reset: drive `reset_n`=0 mid-RUN → all outputs 0 asynchronously; FSM in IDLE after release.
- Free run: `run_sw`=1, `tick` every 5 cycles, 10 ticks → 10 `cpu_ce` pulses, each 1 cycle after its tick; `step_count`=10; `tick_en`=1 throughout.
- Single step, debouncer off: one press → exactly one `cpu_ce`, 3 cycles after the first high sample; held button → no further pulses.
- Bounce, debouncer on with DEBOUNCE_CYCLES=8: button toggles every 3 cycles, then held high for 20 cycles → exactly one `cpu_ce`, at 8+3 cycles after the final settle.
- Halt: `tick` and `halt` in the same cycle in RUN → no `cpu_ce`; `state`=11; `tick_en`=0; steps ignored until `halt`=0, then IDLE.
- Wrap: STEP_COUNT_WIDTH=4, 17 pulses → `step_count`=1.
